// File: rtl/zoom_pkg.sv
// Shared types and defaults for the nearest-neighbour zoom stage.
package zoom_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LINE = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  localparam int DEF_LINE_WIDTH = 320;
  localparam int DEF_N_LINES    = 240;
  localparam int DEF_FACTOR     = 2;

  localparam int COORD_W = 10;
  localparam int SRC_W   = 9;   // holds 0..511 source column/line index
  localparam int REP_W   = 2;   // holds 0..3 replication index

endpackage

// File: rtl/zoom_rep_counter.sv
// Mod-MOD counter with enable; at_max flags the terminal count so the
// caller can chain the next counter off the wrap.
module zoom_rep_counter
  import zoom_pkg::*;
#(
  parameter int MOD = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             en,
  output logic [REP_W-1:0] count,
  output logic             at_max
);

  logic [REP_W-1:0] count_reg;

  assign at_max = (count_reg == REP_W'(MOD - 1));
  assign count  = count_reg;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= at_max ? '0 : count_reg + REP_W'(1);
    end
  end

endmodule

// File: rtl/zoom_replicacao.sv
// Nearest-neighbour zoom: replicates each source pixel FACTOR times across
// and re-reads each source line FACTOR times down via the buffer restart.
module zoom_replicacao
  import zoom_pkg::*;
#(
  parameter int LINE_WIDTH = DEF_LINE_WIDTH,
  parameter int N_LINES    = DEF_N_LINES,
  parameter int FACTOR     = DEF_FACTOR
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start_in,
  input  logic               line_ready_in,
  input  logic [7:0]         pixel_in,
  output logic               rd_data_out,
  output logic               repeat_line_out,
  output logic               line_done_out,
  output logic [7:0]         pixel_out,
  output logic               pixel_valid_out,
  input  logic               pixel_ready_in,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               busy_out,
  output logic               frame_done_out
);

  state_t           state_reg, state_next;
  logic [SRC_W-1:0] src_x_reg, src_x_next;
  logic [SRC_W-1:0] src_y_reg, src_y_next;
  logic [REP_W-1:0] col_rep, row_rep;
  logic             col_wrap, row_wrap;
  logic             transfer, last_x, last_y, line_end;

  assign transfer = (state_reg == ACTIVE) && pixel_ready_in;
  assign last_x   = (src_x_reg == SRC_W'(LINE_WIDTH - 1));
  assign last_y   = (src_y_reg == SRC_W'(N_LINES - 1));
  assign line_end = transfer && col_wrap && last_x;

  zoom_rep_counter #(.MOD(FACTOR)) u_col_rep (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .en     (transfer),
    .count  (col_rep),
    .at_max (col_wrap)
  );

  // Row repeat only steps at the end of each replicated output line.
  zoom_rep_counter #(.MOD(FACTOR)) u_row_rep (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .en     (line_end),
    .count  (row_rep),
    .at_max (row_wrap)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg <= IDLE;
      src_x_reg <= '0;
      src_y_reg <= '0;
    end else begin
      state_reg <= state_next;
      src_x_reg <= src_x_next;
      src_y_reg <= src_y_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    src_x_next      = src_x_reg;
    src_y_next      = src_y_reg;
    rd_data_out     = 1'b0;
    repeat_line_out = 1'b0;
    line_done_out   = 1'b0;
    frame_done_out  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_in) state_next = WAIT_LINE;
      end
      WAIT_LINE: begin
        if (line_ready_in) state_next = ACTIVE;
      end
      ACTIVE: begin
        if (transfer && col_wrap) begin
          if (!last_x) begin
            src_x_next  = src_x_reg + SRC_W'(1);
            rd_data_out = 1'b1;
          end else begin
            // End of an output row: rewind the buffer for the next replica.
            src_x_next      = '0;
            repeat_line_out = 1'b1;
            if (row_wrap) begin
              line_done_out = 1'b1;
              if (!last_y) begin
                src_y_next = src_y_reg + SRC_W'(1);
                state_next = WAIT_LINE;
              end else begin
                src_y_next     = '0;
                frame_done_out = 1'b1;
                state_next     = IDLE;
              end
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign pixel_out       = pixel_in;
  assign pixel_valid_out = (state_reg == ACTIVE);
  assign busy_out        = (state_reg != IDLE);
  assign x_out = COORD_W'(src_x_reg) * COORD_W'(FACTOR) + COORD_W'(col_rep);
  assign y_out = COORD_W'(src_y_reg) * COORD_W'(FACTOR) + COORD_W'(row_rep);

endmodule

// File: tb/tb_zoom_replicacao.sv
// Bench for zoom_replicacao: a 4x2 source frame zoomed by 2 and by 1,
// checked cycle by cycle against an expected transfer list.
module tb_zoom_replicacao;

  localparam int W = 4;
  localparam int N = 2;
  localparam int P_IDLE = 0, P_WAIT = 1, P_ACTIVE = 2;

  typedef struct {
    logic [7:0] pix;
    logic [9:0] x;
    logic [9:0] y;
    bit rd, rep, ld, fd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic line_ready = 1'b0;
  logic pixel_ready = 1'b0;
  logic sel = 1'b0;
  logic start_a, start_b;
  logic [7:0] pix_in;

  logic [7:0] frame_pix [0:N-1][0:W-1];
  bit [0:0] lb_line = '0;
  bit [1:0] ptr = '0;

  logic rd_a, rep_a, ld_a, valid_a, busy_a, fd_a;
  logic rd_b, rep_b, ld_b, valid_b, busy_b, fd_b;
  logic [7:0] pix_a, pix_b;
  logic [9:0] x_a, y_a, x_b, y_b;
  logic m_rd, m_rep, m_ld, m_valid, m_busy, m_fd;
  logic [7:0] m_pix;
  logic [9:0] m_x, m_y;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign pix_in  = frame_pix[lb_line][ptr];
  assign start_a = start & ~sel;
  assign start_b = start & sel;

  assign m_rd    = sel ? rd_b    : rd_a;
  assign m_rep   = sel ? rep_b   : rep_a;
  assign m_ld    = sel ? ld_b    : ld_a;
  assign m_fd    = sel ? fd_b    : fd_a;
  assign m_valid = sel ? valid_b : valid_a;
  assign m_busy  = sel ? busy_b  : busy_a;
  assign m_pix   = sel ? pix_b   : pix_a;
  assign m_x     = sel ? x_b     : x_a;
  assign m_y     = sel ? y_b     : y_a;

  zoom_replicacao #(.LINE_WIDTH(W), .N_LINES(N), .FACTOR(2)) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start_a), .line_ready_in(line_ready),
    .pixel_in(pix_in), .rd_data_out(rd_a), .repeat_line_out(rep_a),
    .line_done_out(ld_a), .pixel_out(pix_a), .pixel_valid_out(valid_a),
    .pixel_ready_in(pixel_ready), .x_out(x_a), .y_out(y_a),
    .busy_out(busy_a), .frame_done_out(fd_a)
  );

  zoom_replicacao #(.LINE_WIDTH(W), .N_LINES(N), .FACTOR(1)) dut_f1 (
    .clk_in(clk), .rst_in(rst), .start_in(start_b), .line_ready_in(line_ready),
    .pixel_in(pix_in), .rd_data_out(rd_b), .repeat_line_out(rep_b),
    .line_done_out(ld_b), .pixel_out(pix_b), .pixel_valid_out(valid_b),
    .pixel_ready_in(pixel_ready), .x_out(x_b), .y_out(y_b),
    .busy_out(busy_b), .frame_done_out(fd_b)
  );

  task automatic fill_random();
    for (int l = 0; l < N; l++)
      for (int p = 0; p < W; p++)
        frame_pix[l][p] = 8'($urandom);
  endtask

  // Runs one frame (or stops after stop_after transfers when >= 0),
  // comparing every cycle with the list of expected transfers.
  task automatic run_frame(input bit s, input bit stall, input int gap,
                           input bit poke, input int stop_after);
    exp_t q[$];
    exp_t e;
    int f, phase, gap_cnt, cycles, xfers;
    bit ev, xfer;
    logic [3:0] exp_str;
    f = s ? 1 : 2;
    for (int sy = 0; sy < N; sy++)
      for (int ry = 0; ry < f; ry++)
        for (int sx = 0; sx < W; sx++)
          for (int rx = 0; rx < f; rx++) begin
            e.pix = frame_pix[sy][sx];
            e.x   = 10'(sx * f + rx);
            e.y   = 10'(sy * f + ry);
            e.rd  = (rx == f - 1) && (sx < W - 1);
            e.rep = (rx == f - 1) && (sx == W - 1);
            e.ld  = e.rep && (ry == f - 1);
            e.fd  = e.ld && (sy == N - 1);
            q.push_back(e);
          end
    sel = s; lb_line = '0; ptr = '0; gap_cnt = 0;
    line_ready = 1'b1; pixel_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n_checks++;
    if (m_busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_after_start got=%b exp=1", m_busy);
    end
    phase = P_WAIT; cycles = 0; xfers = 0;
    while (q.size() > 0 && cycles < 400 && (stop_after < 0 || xfers < stop_after)) begin
      @(negedge clk); cycles++;
      pixel_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (gap_cnt > 0) begin line_ready = 1'b0; gap_cnt--; end
      else line_ready = 1'b1;
      start = poke && ($urandom_range(0, 4) == 0);
      #1;
      ev = (phase == P_ACTIVE);
      xfer = ev && pixel_ready;
      e = q[0];
      n_checks++;
      if (m_valid !== ev) begin
        n_fail++; $display("FAIL valid x=%0d y=%0d got=%b exp=%b", e.x, e.y, m_valid, ev);
      end
      n_checks++;
      if (m_busy !== 1'b1) begin
        n_fail++; $display("FAIL busy_mid_frame got=%b exp=1", m_busy);
      end
      if (ev) begin
        n_checks++;
        if ({m_pix, m_x, m_y} !== {e.pix, e.x, e.y}) begin
          n_fail++;
          $display("FAIL pixel got pix=%0d x=%0d y=%0d exp pix=%0d x=%0d y=%0d",
                   m_pix, m_x, m_y, e.pix, e.x, e.y);
        end
      end
      exp_str = {xfer && e.rd, xfer && e.rep, xfer && e.ld, xfer && e.fd};
      n_checks++;
      if ({m_rd, m_rep, m_ld, m_fd} !== exp_str) begin
        n_fail++;
        $display("FAIL strobes x=%0d y=%0d got rd/rep/ld/fd=%b exp=%b",
                 e.x, e.y, {m_rd, m_rep, m_ld, m_fd}, exp_str);
      end
      @(posedge clk);
      if (xfer) begin
        void'(q.pop_front());
        xfers++;
        $display("xfer f=%0d x=%0d y=%0d pix=%0d rd=%0d rep=%0d ld=%0d fd=%0d",
                 f, e.x, e.y, e.pix, e.rd, e.rep, e.ld, e.fd);
        if (e.rd) ptr = ptr + 2'd1;
        if (e.rep) ptr = '0;
        if (e.ld) begin
          gap_cnt = gap;
          phase = e.fd ? P_IDLE : P_WAIT;
          if (!e.fd) lb_line = lb_line + 1'b1;
        end
      end else if (phase == P_WAIT && line_ready) begin
        phase = P_ACTIVE;
      end
    end
    start = 1'b0;
    if (stop_after < 0) begin
      n_checks++;
      if (q.size() != 0) begin
        n_fail++; $display("FAIL frame_timeout remaining=%0d exp=0", q.size());
      end
      #1;
      n_checks++;
      if ({m_busy, m_valid, m_x, m_y} !== 22'd0) begin
        n_fail++;
        $display("FAIL idle_after_frame got busy=%b valid=%b x=%0d y=%0d exp all 0",
                 m_busy, m_valid, m_x, m_y);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sel = 1'b0;
    #3;
    n_checks++;
    if ({valid_a, busy_a, rd_a, rep_a, ld_a, fd_a} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b exp=000000", {valid_a, busy_a, rd_a, rep_a, ld_a, fd_a});
    end
    n_checks++;
    if ({x_a, y_a} !== 20'd0) begin
      n_fail++; $display("FAIL reset_xy got x=%0d y=%0d exp 0", x_a, y_a);
    end
    n_checks++;
    if ({valid_b, busy_b, x_b, y_b} !== 22'd0) begin
      n_fail++; $display("FAIL reset_f1 got valid=%b busy=%b x=%0d y=%0d exp 0",
                         valid_b, busy_b, x_b, y_b);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset got=%b exp=0", busy_a);
    end
  endtask

  task automatic test_basic();
    for (int p = 0; p < W; p++) begin
      frame_pix[0][p] = 8'(10 * (p + 1));
      frame_pix[1][p] = 8'(10 * (p + 5));
    end
    run_frame(1'b0, 1'b0, 1, 1'b0, -1);
  endtask

  task automatic test_stall();
    fill_random();
    run_frame(1'b0, 1'b1, $urandom_range(1, 4), 1'b1, -1);
  endtask

  task automatic test_line_gap();
    fill_random();
    run_frame(1'b0, 1'b0, 5, 1'b0, -1);
  endtask

  task automatic test_factor1();
    fill_random();
    run_frame(1'b1, 1'b0, 1, 1'b0, -1);
    fill_random();
    run_frame(1'b1, 1'b1, 2, 1'b1, -1);
  endtask

  task automatic test_back_to_back();
    fill_random();
    run_frame(1'b0, 1'b1, 1, 1'b0, -1);
    fill_random();
    run_frame(1'b0, 1'b0, 1, 1'b0, -1);
  endtask

  task automatic test_reset_mid();
    fill_random();
    run_frame(1'b0, 1'b0, 1, 1'b0, 3);
    #2; rst = 1'b1;
    #1;
    n_checks++;
    if ({m_valid, m_busy, m_rd, m_rep, m_ld, m_fd} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_mid_ctrl got=%b exp=000000", {m_valid, m_busy, m_rd, m_rep, m_ld, m_fd});
    end
    n_checks++;
    if ({m_x, m_y} !== 20'd0) begin
      n_fail++; $display("FAIL reset_mid_xy got x=%0d y=%0d exp 0", m_x, m_y);
    end
    @(negedge clk); rst = 1'b0;
    run_frame(1'b0, 1'b0, 1, 1'b0, -1);
  endtask

  initial begin
    for (int l = 0; l < N; l++)
      for (int p = 0; p < W; p++)
        frame_pix[l][p] = '0;
    test_reset();
    test_basic();
    test_line_gap();
    test_stall();
    test_factor1();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
